// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared mode encoding and payload sizing for adder_pipe
//   mode_e    : arithmetic mode carried with each operand beat
//   FLAG_W    : number of flag bits (carry, ovf, sat) riding with the sum
//   payload_w : total stage register width for a given sum width
package adder_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP = 2'd0,
        MODE_USAT = 2'd1,
        MODE_SSAT = 2'd2,
        MODE_RSVD = 2'd3
    } mode_e;

    localparam int unsigned FLAG_W = 3;

    function automatic int unsigned payload_w(input int unsigned width);
        return width + FLAG_W;
    endfunction

endpackage

// File: rtl/adder_pipe_stage.sv
// rtl/adder_pipe_stage.sv - one elastic register slice (valid bit plus payload)
//   clk_i, arst_ni : clock, asynchronous active-low reset
//   load_i         : this slice's ready; when high it captures the upstream beat
//   in_valid_i     : upstream valid
//   in_data_i      : upstream payload
//   valid_o        : slice holds a beat
//   data_o         : held payload
module adder_pipe_stage
    import adder_pkg::*;
#(
    parameter int unsigned DW = 11
) (
    input  logic          clk_i,
    input  logic          arst_ni,
    input  logic          load_i,
    input  logic          in_valid_i,
    input  logic [DW-1:0] in_data_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o
);

    logic          valid_q, valid_d;
    logic [DW-1:0] data_q,  data_d;

    // Payload only moves with a real beat, so a drained slice keeps its last
    // value and the output fields never toggle while invalid.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = in_valid_i;
            if (in_valid_i) begin
                data_d = in_data_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;

endmodule

// File: rtl/adder_pipe.sv
// rtl/adder_pipe.sv - pipelined wrap/saturating adder with valid/ready stages
//   clk_i, arst_ni           : clock, asynchronous active-low reset
//   in_valid_i / in_ready_o  : operand beat handshake
//   opa_i, opb_i, mode_i     : operands and arithmetic mode (adder_pkg::mode_e)
//   out_valid_o / out_ready_i: result beat handshake
//   sum_o                    : result (wrapped or clamped)
//   carry_o, ovf_o           : unsigned carry / signed overflow of the raw add
//   sat_o                    : result was clamped
module adder_pipe
    import adder_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk_i,
    input  logic             arst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] opa_i,
    input  logic [WIDTH-1:0] opb_i,
    input  logic [1:0]       mode_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o,
    output logic             ovf_o,
    output logic             sat_o
);

    localparam int unsigned PW = payload_w(WIDTH);

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             carry;
        logic             ovf;
        logic             sat;
    } payload_t;

    payload_t         in_payload;
    logic [WIDTH:0]   raw;
    logic [STAGES-1:0] stage_valid;
    logic [STAGES-1:0] stage_ready;
    logic [PW-1:0]    stage_data [STAGES];

    // Arithmetic happens once, ahead of stage 0; later stages only carry it.
    always_comb begin
        raw              = {1'b0, opa_i} + {1'b0, opb_i};
        in_payload.carry = raw[WIDTH];
        in_payload.ovf   = (opa_i[WIDTH-1] == opb_i[WIDTH-1]) &&
                           (raw[WIDTH-1] != opa_i[WIDTH-1]);
        in_payload.sum   = raw[WIDTH-1:0];
        in_payload.sat   = 1'b0;
        unique case (mode_e'(mode_i))
            MODE_USAT: begin
                if (in_payload.carry) begin
                    in_payload.sum = '1;
                    in_payload.sat = 1'b1;
                end
            end
            MODE_SSAT: begin
                // On overflow both operands share a sign; clamp toward it.
                if (in_payload.ovf) begin
                    in_payload.sum = opa_i[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                                    : {1'b0, {(WIDTH-1){1'b1}}};
                    in_payload.sat = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Ready chain evaluated in one pass from the output back so the vector
    // depends only on the registered valid bits and out_ready_i.
    always_comb begin
        logic r;
        r           = out_ready_i;
        stage_ready = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            r              = !stage_valid[k] || r;
            stage_ready[k] = r;
        end
    end

    assign in_ready_o = stage_ready[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic          up_valid;
        logic [PW-1:0] up_data;
        if (k == 0) begin : g_first
            assign up_valid = in_valid_i;
            assign up_data  = in_payload;
        end else begin : g_next
            assign up_valid = stage_valid[k-1];
            assign up_data  = stage_data[k-1];
        end
        adder_pipe_stage #(.DW(PW)) u_stage (
            .clk_i      (clk_i),
            .arst_ni    (arst_ni),
            .load_i     (stage_ready[k]),
            .in_valid_i (up_valid),
            .in_data_i  (up_data),
            .valid_o    (stage_valid[k]),
            .data_o     (stage_data[k])
        );
    end

    assign out_valid_o                     = stage_valid[STAGES-1];
    assign {sum_o, carry_o, ovf_o, sat_o}  = stage_data[STAGES-1];

endmodule

// File: tb/tb_adder_pipe.sv
// tb/tb_adder_pipe.sv - self-checking bench for adder_pipe (STAGES 2, 1 and 4)
module tb_adder_pipe;

    typedef struct packed {
        logic [7:0] sum;
        logic       carry;
        logic       ovf;
        logic       sat;
    } res_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] m;
        res_t       exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       arst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] opa = '0;
    logic [7:0] opb = '0;
    logic [1:0] mode = '0;
    logic       out_ready = 1'b1;

    logic       in_ready1, in_ready2, in_ready4;
    logic       out_valid1, out_valid2, out_valid4;
    logic [7:0] sum1, sum2, sum4;
    logic       carry1, carry2, carry4;
    logic       ovf1, ovf2, ovf4;
    logic       sat1, sat2, sat4;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    adder_pipe #(.WIDTH(8), .STAGES(2)) dut2 (
        .clk_i(clk), .arst_ni(arst_n), .in_valid_i(in_valid), .in_ready_o(in_ready2),
        .opa_i(opa), .opb_i(opb), .mode_i(mode), .out_valid_o(out_valid2),
        .out_ready_i(out_ready), .sum_o(sum2), .carry_o(carry2), .ovf_o(ovf2), .sat_o(sat2)
    );
    adder_pipe #(.WIDTH(8), .STAGES(1)) dut1 (
        .clk_i(clk), .arst_ni(arst_n), .in_valid_i(in_valid), .in_ready_o(in_ready1),
        .opa_i(opa), .opb_i(opb), .mode_i(mode), .out_valid_o(out_valid1),
        .out_ready_i(out_ready), .sum_o(sum1), .carry_o(carry1), .ovf_o(ovf1), .sat_o(sat1)
    );
    adder_pipe #(.WIDTH(8), .STAGES(4)) dut4 (
        .clk_i(clk), .arst_ni(arst_n), .in_valid_i(in_valid), .in_ready_o(in_ready4),
        .opa_i(opa), .opb_i(opb), .mode_i(mode), .out_valid_o(out_valid4),
        .out_ready_i(out_ready), .sum_o(sum4), .carry_o(carry4), .ovf_o(ovf4), .sat_o(sat4)
    );

    // Index 0/1/2 = STAGES 1/2/4
    logic ir [3];
    logic ov [3];
    res_t act [3];
    assign ir[0] = in_ready1;
    assign ir[1] = in_ready2;
    assign ir[2] = in_ready4;
    assign ov[0] = out_valid1;
    assign ov[1] = out_valid2;
    assign ov[2] = out_valid4;
    assign act[0] = {sum1, carry1, ovf1, sat1};
    assign act[1] = {sum2, carry2, ovf2, sat2};
    assign act[2] = {sum4, carry4, ovf4, sat4};

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Reference: plain integer arithmetic on unsigned and signed readings.
    function automatic res_t model(input int a, input int b, input int m);
        res_t r;
        int u, sa, sb, ss;
        u  = a + b;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        ss = sa + sb;
        r.carry = (u > 255);
        r.ovf   = (ss > 127) || (ss < -128);
        r.sum   = 8'(u % 256);
        r.sat   = 1'b0;
        if (m == 1 && r.carry) begin
            r.sum = 8'hFF;
            r.sat = 1'b1;
        end else if (m == 2 && r.ovf) begin
            r.sum = (ss > 0) ? 8'h7F : 8'h80;
            r.sat = 1'b1;
        end
        return r;
    endfunction

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        arst_n    = 1'b0;
        repeat (2) @(posedge clk);
        #1 arst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        vec_t vecs [11];
        res_t q [3][$];
        int   got [3];
        bit   started [3];
        int   sent, cyc, ngot;
        bit   in_xfer, out_xfer;
        res_t e;

        vecs[0]  = '{8'hF0, 8'h20, 2'd0, '{8'h10, 1'b1, 1'b0, 1'b0}};
        vecs[1]  = '{8'hF0, 8'h20, 2'd1, '{8'hFF, 1'b1, 1'b0, 1'b1}};
        vecs[2]  = '{8'h10, 8'h20, 2'd1, '{8'h30, 1'b0, 1'b0, 1'b0}};
        vecs[3]  = '{8'h70, 8'h20, 2'd2, '{8'h7F, 1'b0, 1'b1, 1'b1}};
        vecs[4]  = '{8'h80, 8'hFF, 2'd2, '{8'h80, 1'b1, 1'b1, 1'b1}};
        vecs[5]  = '{8'h70, 8'h20, 2'd3, '{8'h90, 1'b0, 1'b1, 1'b0}};
        vecs[6]  = '{8'h00, 8'h00, 2'd2, '{8'h00, 1'b0, 1'b0, 1'b0}};
        vecs[7]  = '{8'hFF, 8'hFF, 2'd1, '{8'hFF, 1'b1, 1'b0, 1'b1}};
        vecs[8]  = '{8'hFF, 8'h01, 2'd2, '{8'h00, 1'b1, 1'b0, 1'b0}};
        vecs[9]  = '{8'h7F, 8'h7F, 2'd0, '{8'hFE, 1'b0, 1'b1, 1'b0}};
        vecs[10] = '{8'h80, 8'h80, 2'd2, '{8'h80, 1'b1, 1'b1, 1'b1}};

        // Reset state, asserted between clock edges
        #1 arst_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid2, 1'b0);
        chk("rst_sum", sum2, 8'h00);
        chk("rst_flags", {carry2, ovf2, sat2}, 3'b000);
        @(posedge clk);
        #1 arst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", in_ready2, 1'b1);

        // Directed vectors, one beat each, latency exactly 2
        foreach (vecs[i]) begin
            @(posedge clk);
            #1;
            opa = vecs[i].a; opb = vecs[i].b; mode = vecs[i].m;
            in_valid = 1'b1; out_ready = 1'b1;
            @(posedge clk);
            #1 in_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("vec%0d_early", i), out_valid2, 1'b0);
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), out_valid2, 1'b1);
            chk($sformatf("vec%0d_sum", i), sum2, vecs[i].exp.sum);
            chk($sformatf("vec%0d_carry", i), carry2, vecs[i].exp.carry);
            chk($sformatf("vec%0d_ovf", i), ovf2, vecs[i].exp.ovf);
            chk($sformatf("vec%0d_sat", i), sat2, vecs[i].exp.sat);
        end

        // Backpressure: fill with 1+1, 2+2 then stall, release and drain in order
        do_reset();
        @(posedge clk);
        #1;
        out_ready = 1'b0; mode = 2'd0; opa = 8'd1; opb = 8'd1; in_valid = 1'b1;
        sent = 0; cyc = 0;
        while (sent < 2 && cyc < 10) begin
            @(negedge clk);
            in_xfer = in_ready2;
            @(posedge clk);
            #1;
            if (in_xfer) begin
                sent++;
                opa = 8'(sent + 1); opb = 8'(sent + 1);
            end
            cyc++;
        end
        chk("bp_accepted", sent, 2);
        repeat (3) begin
            @(negedge clk);
            chk("bp_full_ready", in_ready2, 1'b0);
            chk("bp_hold_valid", out_valid2, 1'b1);
            chk("bp_hold_sum", sum2, 8'h02);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        #1 chk("bp_nobubble_ready", in_ready2, 1'b1);
        ngot = 0; cyc = 0;
        while (ngot < 4 && cyc < 20) begin
            @(negedge clk);
            chk("bp_drain_valid", out_valid2, 1'b1);
            if (out_valid2) chk("bp_drain_sum", sum2, 8'(2 * (ngot + 1)));
            in_xfer  = in_valid && in_ready2;
            out_xfer = out_valid2 && out_ready;
            @(posedge clk);
            #1;
            if (in_xfer) begin
                sent++;
                if (sent < 4) begin
                    opa = 8'(sent + 1); opb = 8'(sent + 1);
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_xfer) ngot++;
            cyc++;
        end
        chk("bp_drain_count", ngot, 4);
        @(negedge clk);
        chk("bp_empty", out_valid2, 1'b0);

        // Reset with two beats in flight
        do_reset();
        @(posedge clk);
        #1;
        out_ready = 1'b0; opa = 8'd5; opb = 8'd6; mode = 2'd0; in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("mid_pre_valid", out_valid2, 1'b1);
        chk("mid_pre_sum", sum2, 8'd11);
        #2 arst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid2, 1'b0);
        chk("mid_rst_sum", sum2, 8'h00);
        chk("mid_rst_flags", {carry2, ovf2, sat2}, 3'b000);
        @(posedge clk);
        #1;
        arst_n = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("mid_post_ready", in_ready2, 1'b1);
        repeat (6) begin
            @(negedge clk);
            chk("mid_no_stale", out_valid2, 1'b0);
        end

        // Random streaming against the reference model on all three depths
        do_reset();
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        opa = 8'($urandom); opb = 8'($urandom); mode = 2'($urandom_range(0, 3));
        in_valid = 1'b1;
        sent = 0; cyc = 0;
        for (int i = 0; i < 3; i++) begin
            got[i] = 0; started[i] = 1'b0;
        end
        while ((got[0] < 100 || got[1] < 100 || got[2] < 100) && cyc < 400) begin
            @(negedge clk);
            in_xfer = 1'b0;
            if (in_valid) begin
                chk("stream_in_ready", {ir[0], ir[1], ir[2]}, 3'b111);
                in_xfer = ir[0] && ir[1] && ir[2];
            end
            if (in_xfer) begin
                e = model(int'(opa), int'(opb), int'(mode));
                for (int i = 0; i < 3; i++) q[i].push_back(e);
            end
            for (int i = 0; i < 3; i++) begin
                if (ov[i]) started[i] = 1'b1;
                if (started[i] && got[i] < 100)
                    chk($sformatf("stream%0d_continuous", i), ov[i], 1'b1);
                if (ov[i]) begin
                    if (q[i].size() == 0) begin
                        chk($sformatf("stream%0d_extra", i), 1, 0);
                    end else begin
                        e = q[i].pop_front();
                        chk($sformatf("stream%0d_result", i), act[i], e);
                    end
                    got[i]++;
                end
            end
            @(posedge clk);
            #1;
            if (in_xfer) begin
                sent++;
                if (sent < 100) begin
                    opa = 8'($urandom); opb = 8'($urandom);
                    mode = 2'($urandom_range(0, 3));
                end else begin
                    in_valid = 1'b0;
                end
            end
            cyc++;
        end
        for (int i = 0; i < 3; i++) chk($sformatf("stream%0d_count", i), got[i], 100);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
